// File: rtl/channel_decorrelator.sv
// rtl/channel_decorrelator.sv - FLAC inter-channel decorrelation; DECORR_SATURATE_EN enables output clamping
module channel_decorrelator #(
  parameter int SAMPLE_W  = 16,
  parameter int BUF_DEPTH = 4096,
  parameter int ADDR_W    = 12
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic [3:0]          iChanAssign,
  input  logic [15:0]         iBlockSize,
  input  logic                iValid,
  input  logic [SAMPLE_W:0]   iSample,
  output logic [SAMPLE_W-1:0] oLeft,
  output logic [SAMPLE_W-1:0] oRight,
  output logic                oValid,
  output logic                oDone,
  output logic                oBusy,
  output logic                oError
);

  localparam int IW = SAMPLE_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_CH0, S_CH1, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d, last_idx_q, last_idx_d;
  logic [3:0]          mode_q, mode_d;
  logic                busy_q, busy_d, err_q, err_d;
  logic                v1_q, v1_d, last1_q, last1_d;
  logic [SAMPLE_W:0]   b1_q, b1_d, a1_q;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic                valid_q, valid_d, done_q, done_d;
  logic                wr_en, rd_en, acc, acc_last, code_ok, size_ok, ovf;
  logic [SAMPLE_W-1:0] left_res, right_res;
  logic signed [IW-1:0] a_x, b_x, m_x, s_x, d_x, l_x, r_x;
  logic [SAMPLE_W:0]   mem [BUF_DEPTH];
  logic [ADDR_W-1:0]   addr;

  assign addr    = cnt_q[ADDR_W-1:0];
  assign code_ok = iChanAssign inside {4'd0, 4'd1, 4'd8, 4'd9, 4'd10};
  assign size_ok = (iBlockSize != 16'd0) && ({16'd0, iBlockSize} <= 32'(BUF_DEPTH));

`ifdef DECORR_SATURATE_EN
  function automatic logic fits(input logic [IW-1:0] v);
    return (v[IW-1:SAMPLE_W-1] == '0) || (v[IW-1:SAMPLE_W-1] == '1);
  endfunction

  function automatic logic [SAMPLE_W-1:0] clamp(input logic [IW-1:0] v);
    if (fits(v)) return v[SAMPLE_W-1:0];
    return v[IW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
  endfunction
`endif

  // Frame sequencing: accept start, count channel-0 writes then channel-1 reads, drain.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    acc        = 1'b0;
    acc_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          if (code_ok && size_ok) begin
            mode_d     = iChanAssign;
            last_idx_d = iBlockSize - 16'd1;
            cnt_d      = 16'd0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            state_d    = (iChanAssign == 4'd0) ? S_CH1 : S_CH0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CH0: begin
        if (iValid) begin
          wr_en = ~iReset;
          if (cnt_q == last_idx_q) begin
            cnt_d   = 16'd0;
            state_d = S_CH1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_CH1: begin
        if (iValid) begin
          acc   = 1'b1;
          rd_en = (mode_q != 4'd0);
          if (cnt_q == last_idx_q) begin
            acc_last = 1'b1;
            cnt_d    = 16'd0;
            state_d  = S_FLUSH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        if (done_q) state_d = S_IDLE;
      end
    endcase
    if (done_q) busy_d = 1'b0;
    if (v1_q && ovf) err_d = 1'b1;
  end

  // Decorrelation arithmetic on the stage-1 pair and output register next-values.
  always_comb begin
    a_x = {a1_q[SAMPLE_W], a1_q};
    b_x = {b1_q[SAMPLE_W], b1_q};
    m_x = (a_x <<< 1) | {{(IW-1){1'b0}}, b_x[0]};
    s_x = m_x + b_x;
    d_x = m_x - b_x;
    case (mode_q)
      4'd0:    begin l_x = b_x;        r_x = b_x;        end
      4'd8:    begin l_x = a_x;        r_x = a_x - b_x;  end
      4'd9:    begin l_x = a_x + b_x;  r_x = b_x;        end
      4'd10:   begin l_x = s_x >>> 1;  r_x = d_x >>> 1;  end
      default: begin l_x = a_x;        r_x = b_x;        end
    endcase
`ifdef DECORR_SATURATE_EN
    left_res  = clamp(l_x);
    right_res = clamp(r_x);
    ovf       = ~fits(l_x) | ~fits(r_x);
`else
    left_res  = l_x[SAMPLE_W-1:0];
    right_res = r_x[SAMPLE_W-1:0];
    ovf       = 1'b0;
`endif
    v1_d    = acc;
    last1_d = acc_last;
    b1_d    = acc ? iSample : b1_q;
    valid_d = v1_q;
    done_d  = v1_q & last1_q;
    left_d  = v1_q ? left_res : left_q;
    right_d = v1_q ? right_res : right_q;
  end

  // Control, pipeline and output registers.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      last_idx_q <= 16'd0;
      mode_q     <= 4'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      v1_q       <= 1'b0;
      last1_q    <= 1'b0;
      b1_q       <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      v1_q       <= v1_d;
      last1_q    <= last1_d;
      b1_q       <= b1_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // Channel-0 buffer: write during S_CH0, registered read during S_CH1.
  always_ff @(posedge iClock) begin
    if (wr_en) mem[addr] <= iSample;
    if (rd_en) a1_q <= mem[addr];
  end

  assign oLeft  = left_q;
  assign oRight = right_q;
  assign oValid = valid_q;
  assign oDone  = done_q;
  assign oBusy  = busy_q;
  assign oError = err_q;

endmodule

// File: tb/tb_channel_decorrelator.sv
// tb/tb_channel_decorrelator.sv - randomized self-checking bench for channel_decorrelator
module tb_channel_decorrelator;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStart = 1'b0;
  logic [3:0]  iChanAssign = 4'd0;
  logic [15:0] iBlockSize = 16'd0;
  logic        iValid = 1'b0;
  logic [16:0] iSample = '0;
  logic [15:0] oLeft, oRight;
  logic        oValid, oDone, oBusy, oError;

  channel_decorrelator dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iChanAssign(iChanAssign),
    .iBlockSize(iBlockSize), .iValid(iValid), .iSample(iSample),
    .oLeft(oLeft), .oRight(oRight), .oValid(oValid), .oDone(oDone),
    .oBusy(oBusy), .oError(oError)
  );

  always #5 iClock = ~iClock;

  int cyc = 0;
  always @(posedge iClock) cyc++;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   ch0[64];
  int   ch1[64];
  int   exp_err;
  int   codes[5] = '{0, 1, 8, 9, 10};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: FLAC decorrelation rules on plain integers, then clamp or truncate.
  function automatic void model(input int code, input int a, input int b,
                                output logic [15:0] l, output logic [15:0] r, output bit o);
    int lv, rv, m;
    case (code)
      0:  begin lv = b; rv = b; end
      8:  begin lv = a; rv = a - b; end
      9:  begin lv = a + b; rv = b; end
      10: begin m = a * 2 + (b & 1); lv = (m + b) >>> 1; rv = (m - b) >>> 1; end
      default: begin lv = a; rv = b; end
    endcase
    o = 1'b0;
`ifdef DECORR_SATURATE_EN
    if (lv > 32767)  begin lv = 32767;  o = 1'b1; end
    if (lv < -32768) begin lv = -32768; o = 1'b1; end
    if (rv > 32767)  begin rv = 32767;  o = 1'b1; end
    if (rv < -32768) begin rv = -32768; o = 1'b1; end
`endif
    l = lv[15:0];
    r = rv[15:0];
  endfunction

  // Scoreboard: every oValid must match the oldest expected pair, on its predicted cycle.
  always @(negedge iClock) begin
    exp_t e;
    if (oValid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", {31'd0, oValid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("left", {16'd0, oLeft}, {16'd0, e.l});
        check("right", {16'd0, oRight}, {16'd0, e.r});
        check("done_flag", {31'd0, oDone}, {31'd0, e.done});
        check("latency_cycle", cyc, e.cyc);
      end
    end else begin
      check("done_without_valid", {31'd0, oDone}, 32'd0);
    end
  end

  task automatic sync();
    @(posedge iClock);
    #1;
  endtask

  task automatic start(input int code, input int bs);
    sync();
    iStart = 1'b1;
    iChanAssign = 4'(code);
    iBlockSize = 16'(bs);
    sync();
    iStart = 1'b0;
  endtask

  task automatic drive(input int x, input bit push, input logic [15:0] l, input logic [15:0] r,
                       input bit last, input int gap);
    exp_t e;
    iValid = 1'b1;
    iSample = 17'(x);
    if (push) begin
      e.l = l; e.r = r; e.done = last; e.cyc = cyc + 2;
      q.push_back(e);
    end
    sync();
    iValid = 1'b0;
    repeat (gap) sync();
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge iClock);
    while (!oDone && t < 40) begin
      @(negedge iClock);
      t++;
    end
    check("done_seen", {31'd0, oDone}, 32'd1);
    check("busy_at_done", {31'd0, oBusy}, 32'd1);
    @(negedge iClock);
    check("busy_after_done", {31'd0, oBusy}, 32'd0);
    check("error_flag", {31'd0, oError}, exp_err);
    check("queue_empty", q.size(), 32'd0);
    q.delete();
  endtask

  task automatic run_frame(input int code, input int bs, input int gap, input bit rnd);
    logic [15:0] l, r;
    bit o;
    int g;
    exp_err = 0;
    start(code, bs);
    if (code != 0) begin
      for (int i = 0; i < bs; i++) begin
        g = rnd ? int'($urandom_range(0, 2)) : gap;
        drive(ch0[i], 1'b0, 16'd0, 16'd0, 1'b0, g);
      end
    end
    for (int i = 0; i < bs; i++) begin
      model(code, ch0[i], ch1[i], l, r, o);
      if (o) exp_err = 1;
      g = rnd ? int'($urandom_range(0, 2)) : gap;
      if (i == bs - 1) g = 0;
      drive(ch1[i], 1'b1, l, r, (i == bs - 1), g);
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int code, bs;
    logic [15:0] l, r;
    bit o;

    repeat (3) sync();
    @(negedge iClock);
    check("rst_left", {16'd0, oLeft}, 32'd0);
    check("rst_right", {16'd0, oRight}, 32'd0);
    check("rst_valid", {31'd0, oValid}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_error", {31'd0, oError}, 32'd0);
    sync();
    iReset = 1'b0;
    repeat (2) sync();

    ch0[0] = 100; ch1[0] = 3;
    run_frame(10, 1, 0, 1'b0);

    ch0[0] = 1000; ch0[1] = 0; ch0[2] = -1; ch0[3] = 32767;
    ch1[0] = -24;  ch1[1] = 0; ch1[2] = -1; ch1[3] = 0;
    run_frame(8, 4, 0, 1'b0);

    ch0[0] = -5; ch0[1] = 10; ch1[0] = -7; ch1[1] = 20;
    run_frame(9, 2, 3, 1'b0);

    ch1[0] = 5; ch1[1] = -6; ch1[2] = 7;
    run_frame(0, 3, 0, 1'b0);

    start(3, 4);
    @(negedge iClock);
    check("bad_code_error", {31'd0, oError}, 32'd1);
    check("bad_code_busy", {31'd0, oBusy}, 32'd0);
    sync();
    for (int i = 0; i < 4; i++) drive(i + 1, 1'b0, 16'd0, 16'd0, 1'b0, 0);
    repeat (4) sync();

    ch1[0] = 42;
    run_frame(0, 1, 0, 1'b0);
    start(1, 4097);
    @(negedge iClock);
    check("big_block_error", {31'd0, oError}, 32'd1);
    check("big_block_busy", {31'd0, oBusy}, 32'd0);
    run_frame(0, 1, 0, 1'b0);
    start(1, 0);
    @(negedge iClock);
    check("zero_block_error", {31'd0, oError}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      ch0[i] = int'($urandom_range(0, 131071)) - 65536;
      ch1[i] = int'($urandom_range(0, 131071)) - 65536;
    end
    start(1, 8);
    for (int i = 0; i < 8; i++) drive(ch0[i], 1'b0, 16'd0, 16'd0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      model(1, ch0[i], ch1[i], l, r, o);
      drive(ch1[i], (i < 2), l, r, 1'b0, 0);
    end
    iReset = 1'b1;
    sync();
    @(negedge iClock);
    check("abort_left", {16'd0, oLeft}, 32'd0);
    check("abort_right", {16'd0, oRight}, 32'd0);
    check("abort_valid", {31'd0, oValid}, 32'd0);
    check("abort_busy", {31'd0, oBusy}, 32'd0);
    sync();
    iReset = 1'b0;
    for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, 100)), 1'b0, 16'd0, 16'd0, 1'b0, 0);
    repeat (3) sync();
    check("abort_queue", q.size(), 32'd0);
    q.delete();

    for (int i = 0; i < 8; i++) begin
      ch0[i] = int'($urandom_range(0, 131071)) - 65536;
      ch1[i] = int'($urandom_range(0, 131071)) - 65536;
    end
    run_frame(1, 8, 0, 1'b0);

    ch0[0] = 32767; ch1[0] = -32768;
    run_frame(8, 1, 0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      code = codes[$urandom_range(0, 4)];
      bs = int'($urandom_range(1, 12));
      for (int i = 0; i < bs; i++) begin
        if (code == 10) ch0[i] = int'($urandom_range(0, 65535)) - 32768;
        else            ch0[i] = int'($urandom_range(0, 131071)) - 65536;
        ch1[i] = int'($urandom_range(0, 131071)) - 65536;
      end
      run_frame(code, bs, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel_decorrelator.md
Name: channel_decorrelator

Overview:
Sits directly downstream of the per-channel subframe decoder. Takes the subframe sample stream for one FLAC frame: all channel-0 samples, then all channel-1 samples. Undoes inter-channel decorrelation (independent, left/side, side/right, mid/side) and emits reconstructed left/right sample pairs. Channel-0 samples are held in an internal buffer until the matching channel-1 sample arrives.

Parameters:
SAMPLE_W, 16, width of reconstructed output samples
BUF_DEPTH, 4096, channel-0 buffer depth in samples (power of 2)
ADDR_W, 12, log2(BUF_DEPTH)

Ports:
iClock  in  1  clock
iReset  in  1  synchronous active-high reset
iStart  in  1  one-cycle pulse; latches iChanAssign and iBlockSize; starts a frame
iChanAssign  in  4  FLAC channel assignment code: 0 mono, 1 independent stereo, 8 left/side, 9 side/right, 10 mid/side
iBlockSize  in  16  samples per channel in this frame (1..BUF_DEPTH)
iValid  in  1  strobe: iSample carries a decoded subframe sample
iSample  in  SAMPLE_W+1  signed subframe sample, sign-extended (side channel needs the extra bit)
oLeft  out  SAMPLE_W  signed left (or mono) sample
oRight  out  SAMPLE_W  signed right sample (equals oLeft in mono)
oValid  out  1  one-cycle strobe: oLeft/oRight valid
oDone  out  1  one-cycle pulse with the last output pair of the frame
oBusy  out  1  high from iStart until oDone
oError  out  1  sticky until next iStart or reset; unsupported iChanAssign or iBlockSize out of range

Behaviour:
- Reset values: oLeft=0, oRight=0, oValid=0, oDone=0, oBusy=0, oError=0, state S_IDLE, counters 0. Buffer contents are not cleared.
- Reset mid-frame aborts the frame immediately. No further oValid until the next iStart.
- States:
  - S_IDLE: wait for iStart.
  - S_CH0: each iValid writes iSample to buf[cnt], then cnt++. When cnt reaches iBlockSize-1 with iValid, clear cnt and go to S_CH1.
  - S_CH1: each iValid reads buf[cnt] and computes the pair; cnt++. When the last sample is accepted, go to S_FLUSH.
  - S_FLUSH: wait for the pipeline to drain, pulse oDone with the last oValid, return to S_IDLE.
- Mono (code 0): skips S_CH0. S_CH1 passes iSample through to both outputs with no buffer read.
- iStart with a code outside {0,1,8,9,10}, or iBlockSize==0, or iBlockSize>BUF_DEPTH: set oError, stay in S_IDLE, ignore samples.
- iStart while oBusy: ignored.
- iValid in S_IDLE or S_FLUSH: ignored.
- Latency: iValid of a channel-1 (or mono) sample at cycle t gives oValid at t+2. Stage 1 is the registered buffer read plus a delayed sample; stage 2 is the arithmetic and output registers.
- Back-to-back iValid every cycle is supported. No backpressure; the consumer must accept every oValid.
- Arithmetic uses (SAMPLE_W+2)-bit signed intermediates. Here a = buffered channel-0 sample, b = current sample.
  - 1 independent: L=a, R=b.
  - 8 left/side: L=a, R=a-b.
  - 9 side/right: L=a+b, R=b.
  - 10 mid/side: m=(a<<1)|(b&1); L=(m+b)>>>1; R=(m-b)>>>1 (arithmetic shift).
- Output is the low SAMPLE_W bits of each result (truncation).
- iBlockSize=1: a single write, then a single pair; oDone coincides with the only oValid.
- Buffer address wraps mod BUF_DEPTH. This is never reached when iBlockSize is in range.

Optional Feature:
DECORR_SATURATE_EN
- Defined: each result is clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] before output. An overflow also sets oError, but output continues.
- Undefined: plain truncation to SAMPLE_W bits; oError is never set by overflow.
- Latency is the same either way.

Test Plan:
1. Reset, iStart code 10, block 1; ch0 sample 100, ch1 sample 3 -> one oValid with L=102, R=99, oDone high on the same cycle, oBusy then drops.
2. Code 8, block 4; ch0 {1000,0,-1,32767}, ch1 {-24,0,-1,0}, iValid every cycle -> R={1024,0,0,32767}, L equals ch0, four consecutive oValid starting 2 cycles after the first ch1 iValid.
3. Code 9, block 2; ch0 {-5,10}, ch1 {-7,20}, iValid gapped by 3 idle cycles -> L={-12,30}, R={-7,20}, each oValid exactly 2 cycles after its iValid.
4. Code 0, block 3; samples {5,-6,7} -> L=R={5,-6,7}, oDone on the third output; no buffer writes occur.
5. iStart code 3 -> oError=1, no oValid for any following iValid. iStart with block 4097 -> oError=1.
6. Code 1, block 8; assert iReset after 3 ch1 samples -> all outputs 0 next cycle, no further oValid. A new frame then decodes correctly. With DECORR_SATURATE_EN: code 8, a=32767, b=-32768 -> R=32767 and oError=1.
